// File: rtl/repeat_ec_sched.sv
// Scheduler for "lhs = repeat(n) @(posedge clk) rhs": the rhs is sampled when the
// request is accepted and committed to out_data n edges later. Up to DEPTH commits can be pending.
module repeat_ec_sched #(
  parameter int unsigned W     = 8,
  parameter int unsigned CW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [W-1:0]                 req_data,
  input  logic [CW-1:0]                req_count,
  output logic [W-1:0]                 out_data,
  output logic                         out_valid,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic [7:0]                   collisions
);

  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam int unsigned RW = CW - 1;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW = $clog2(DEPTH + 2);

  logic [DEPTH-1:0] r_vld;
  logic [W-1:0]     r_data  [DEPTH];
  logic [RW-1:0]    r_rem   [DEPTH];
  logic [DEPTH-1:0] r_older [DEPTH];  // r_older[i][j]: slot i was accepted before slot j
  logic [PW-1:0]    r_pending;
  logic [W-1:0]     r_out_data;
  logic             r_out_valid;
  logic [7:0]       r_coll;

  logic             w_accept;
  logic             w_immediate;
  logic             w_alloc;
  logic [DEPTH-1:0] w_mature;
  logic [IW-1:0]    w_free_idx;
  logic             w_free_found;
  logic [IW-1:0]    w_win_idx;
  logic             w_win_found;
  logic             w_newest;
  logic [NW-1:0]    w_nmat;
  logic [NW-1:0]    w_ncommit;
  logic [PW-1:0]    w_pending_nxt;
  logic [8:0]       w_coll_sum;

  assign req_ready  = (r_pending < PW'(DEPTH));
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign pending    = r_pending;
  assign collisions = r_coll;

  // Acceptance, maturity, slot choice and same-edge arbitration (newest wins)
  always_comb begin
    w_accept     = req_valid && req_ready;
    w_immediate  = w_accept && (req_count[CW-1] || (req_count == '0));
    w_alloc      = w_accept && !w_immediate;
    w_mature     = '0;
    w_free_idx   = '0;
    w_free_found = 1'b0;
    w_win_idx    = '0;
    w_win_found  = 1'b0;
    w_newest     = 1'b0;
    w_nmat       = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_mature[i] = r_vld[i] && (r_rem[i] == RW'(1));
      w_nmat      = w_nmat + NW'(w_mature[i]);
      if (!r_vld[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = IW'(i);
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_newest = w_mature[i];
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (j != i && w_mature[j] && !r_older[j][i]) w_newest = 1'b0;
      end
      if (w_newest) begin
        w_win_found = 1'b1;
        w_win_idx   = IW'(i);
      end
    end
    w_ncommit     = w_nmat + NW'(w_immediate);
    w_pending_nxt = r_pending + PW'(w_alloc) - PW'(w_nmat);
    w_coll_sum    = 9'(r_coll) + 9'(w_ncommit) - 9'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld       <= '0;
      r_pending   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_coll      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_data[i]  <= '0;
        r_rem[i]   <= '0;
        r_older[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (w_mature[i])   r_vld[i] <= 1'b0;
        else if (r_vld[i]) r_rem[i] <= r_rem[i] - RW'(1);
      end
      // A slot freed at this edge is still valid in r_vld, so it cannot be reused until next edge
      if (w_alloc && w_free_found) begin
        r_vld[w_free_idx]   <= 1'b1;
        r_data[w_free_idx]  <= req_data;
        r_rem[w_free_idx]   <= req_count[RW-1:0];
        r_older[w_free_idx] <= '0;
        for (int j = 0; j < int'(DEPTH); j++) begin
          if (IW'(j) != w_free_idx) r_older[j][w_free_idx] <= 1'b1;
        end
      end
      r_pending   <= w_pending_nxt;
      r_out_valid <= (w_ncommit != '0);
      if (w_immediate)      r_out_data <= req_data;
      else if (w_win_found) r_out_data <= r_data[w_win_idx];
      if (w_ncommit > NW'(1)) r_coll <= w_coll_sum[8] ? 8'hFF : w_coll_sum[7:0];
    end
  end

endmodule
